ln_normalize_affine_pipe: RTL and testbench
===========================================

# ln_normalize_affine_pipe

Parametrised LayerNorm final stage. Per lane it computes y = sat(((x − mean) · inv_sqrt) · gamma + beta) across LANES parallel lanes, in fixed-point with a configurable number of fractional bits and a selectable rounding mode. It sits after the mean/variance/inverse-sqrt stages and before the result writeback buffer. Relative to the previous normalize stage it adds:

- parameters for lane count, data width and fractional bits;
- valid/ready backpressure;
- inferred multipliers, with no vendor IP;
- per-lane saturation reporting.

## Interface

Parameters:

- LANES, 64, number of parallel lanes
- DW, 16, signed width of raw, gamma, beta, mean and result
- INV_W, 17, signed width of inv_sqrt
- FRAC, 10, fractional bits of every fixed-point operand (must be ≥ 1)
- ADDR_W, 6, width of the tag/address carried alongside data
- ROUND, 1, 1 = round-half-up before each right shift, 0 = truncate (arithmetic shift)

Ports:

- i_clk in 1: single clock, rising edge
- i_rst_n in 1: asynchronous, active-low reset
- i_valid in 1: input beat valid
- o_ready out 1: block accepts a beat this cycle
- i_addr in ADDR_W: tag travelling with the beat
- i_mean in DW: signed mean, constant over the beat
- i_inv_sqrt in INV_W: signed 1/σ, Q(FRAC)
- i_raw_flat in LANES·DW: lane g at bits [DW·g +: DW], signed
- i_gamma_flat in LANES·DW: per-lane gamma, signed, same packing
- i_beta_flat in LANES·DW: per-lane beta, signed, same packing
- o_valid out 1: output beat valid
- i_ready in 1: downstream accepts output
- o_data_flat out LANES·DW: normalized results, same packing
- o_addr out ADDR_W: tag of the output beat
- o_sat_mask out LANES: per-lane flag, 1 = that lane saturated in this output beat
- o_sat_sticky out 1: set on any saturation, held until cleared
- i_sat_clr in 1: synchronous clear of o_sat_sticky

## Operation

Five-stage pipeline. All stages advance together on adv = o_ready. The input sampled on a cycle with i_valid & o_ready is written into S1.

- **S1:** d = raw − mean, DW+1 signed. gamma, beta, addr and valid are registered alongside.
- **S2:** p1 = d · inv_sqrt, DW+INV_W+1 signed, full precision.
- **S3:** n = shr(p1). Width is DW+INV_W+1−FRAC, kept without clamping.
- **S4:** p2 = n · gamma, full precision.
- **S5 (output register):** s = shr(p2) + beta, computed at full width plus 1 bit. Then:
  - s is saturated to [−2^(DW−1), 2^(DW−1)−1] and written to o_data_flat.
  - o_sat_mask[g] is set when lane g clamped.
  - o_sat_sticky is set if any mask bit is set on an accepted output.

Definition of shr(v):

- ROUND=1: (v + 2^(FRAC−1)) >>> FRAC.
- ROUND=0: v >>> FRAC.

Backpressure and valids:

- o_ready = !o_valid | i_ready, so the whole pipe freezes while the output is held.
- Bubbles (valid=0) propagate and are not collapsed.
- Data registers of invalid stages may change freely.
- o_addr, o_data_flat and o_sat_mask are meaningful only when o_valid=1.

Sticky flag:

- i_sat_clr has priority over a same-cycle set, and clears the flag.
- An accepted saturating beat in the cycle after the clear sets it again.

## Timing

- Reset (i_rst_n low, async) sets all of the following to 0, every stage valid included:
  - o_valid, o_data_flat, o_addr, o_sat_mask, o_sat_sticky.
- o_ready is 1 in reset.
- Reset asserted mid-stream discards all in-flight beats.
- After release, the first accepted beat appears on o_valid exactly 5 cycles later, given i_ready held high.
- Latency is 5 adv-cycles from input accept to o_valid. Throughput is one beat per cycle with i_ready=1.
- Stall: while o_valid=1 and i_ready=0, the following stay stable and o_ready=0:
  - o_data_flat, o_addr, o_sat_mask;
  - all pipeline registers.
- Simultaneous output pop and input push on the same cycle is legal, with no bubble inserted.
- Beats exit in input order. o_addr always equals the i_addr of the same beat.

## Test plan

1. **Unity path.** FRAC=10, mean=1024, inv=1024, gamma=1024, beta=0, all raw=2048, addr=5, i_ready=1.
   - Expect o_data lanes=1024, o_addr=5, o_sat_mask=0, o_valid exactly 5 cycles after accept.
2. **Positive saturation.** raw=32767, mean=−32768, inv=4096, gamma=1024, beta=0.
   - Expect lanes=32767, o_sat_mask all ones, o_sat_sticky=1.
   - Then pulse i_sat_clr and expect sticky=0 next cycle.
   - Repeat with gamma=−1024: expect −32768 and the mask set.
3. **Rounding.** raw=1, mean=0, inv=512, gamma=1024, beta=0.
   - ROUND=1: expect 1. ROUND=0: expect 0.
   - With raw=−1: ROUND=1 gives 0, ROUND=0 gives −1.
4. **Backpressure.** Stream 20 beats with addr=0..19 and per-lane distinct raw. Toggle i_ready on a random pattern.
   - Expect every beat exactly once, in order, with addr and data matching a reference model.
   - Outputs stay stable during stalls, and o_ready=!o_valid|i_ready every cycle.
5. **Reset mid-stream.** Assert i_rst_n low with 3 beats in flight.
   - Outputs go to 0 immediately.
   - No stale beat emerges after release.
   - A new beat accepted after release exits 5 cycles later.
6. **Parameter sweep.** LANES=4, DW=24, FRAC=16, INV_W=25 with random operands, ROUND ∈ {0,1}.
   - Expect a bit-exact match against the reference model, including mask bits.

Source files
------------

// File: rtl/ln_normalize_affine_pipe.sv
`default_nettype none
// ============================================================================
// ln_normalize_affine_pipe
// LayerNorm final stage: y = sat(((x - mean) * inv_sqrt) * gamma + beta),
// LANES lanes, five-stage valid/ready pipeline with saturation reporting.
// Revision: 1.0
// ============================================================================
module ln_normalize_affine_pipe #(
  parameter int LANES  = 64,
  parameter int DW     = 16,
  parameter int INV_W  = 17,
  parameter int FRAC   = 10,
  parameter int ADDR_W = 6,
  parameter int ROUND  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic signed [DW-1:0]     i_mean,
  input  logic signed [INV_W-1:0]  i_inv_sqrt,
  input  logic [LANES*DW-1:0]      i_raw_flat,
  input  logic [LANES*DW-1:0]      i_gamma_flat,
  input  logic [LANES*DW-1:0]      i_beta_flat,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [LANES*DW-1:0]      o_data_flat,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [LANES-1:0]         o_sat_mask,
  output logic                     o_sat_sticky,
  input  logic                     i_sat_clr
);

  localparam int c_DW1  = DW + 1;
  localparam int c_P1W  = DW + INV_W + 1;
  localparam int c_NW   = c_P1W - FRAC;
  localparam int c_P2W  = c_NW + DW;
  localparam int c_P2RW = c_P2W + 1;
  localparam int c_SW   = c_P2W + 2;

  localparam logic signed [c_P1W-1:0]  c_RND1 = (ROUND != 0) ? (c_P1W'(1) << (FRAC - 1)) : '0;
  localparam logic signed [c_P2RW-1:0] c_RND2 = (ROUND != 0) ? (c_P2RW'(1) << (FRAC - 1)) : '0;
  localparam logic signed [DW-1:0]     c_YMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]     c_YMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [c_SW-1:0]   c_MAX  = c_SW'(c_YMAX);
  localparam logic signed [c_SW-1:0]   c_MIN  = c_SW'(c_YMIN);

  logic                     w_adv;
  logic [4:0]               r_vld;
  logic [ADDR_W-1:0]        r_addr [5];
  logic signed [INV_W-1:0]  r_inv;
  logic                     r_sticky;

  // The whole pipe advances together; a held output freezes every stage.
  assign w_adv        = ~r_vld[4] | i_ready;
  assign o_ready      = w_adv;
  assign o_valid      = r_vld[4];
  assign o_addr       = r_addr[4];
  assign o_sat_sticky = r_sticky;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_inv <= '0;
      for (int s = 0; s < 5; s++) r_addr[s] <= '0;
    end else if (w_adv) begin
      r_vld     <= {r_vld[3:0], i_valid};
      r_inv     <= i_inv_sqrt;
      r_addr[0] <= i_addr;
      for (int s = 1; s < 5; s++) r_addr[s] <= r_addr[s-1];
    end
  end

  // Clear wins over a set in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sticky <= 1'b0;
    end else if (i_sat_clr) begin
      r_sticky <= 1'b0;
    end else if (r_vld[4] && i_ready && (|o_sat_mask)) begin
      r_sticky <= 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      logic signed [DW-1:0]     w_raw, w_gam, w_bet;
      logic signed [c_P1W-1:0]  w_p1, w_p1r;
      logic signed [c_NW-1:0]   w_n;
      logic signed [c_P2W-1:0]  w_p2;
      logic signed [c_P2RW-1:0] w_p2r, w_t;
      logic signed [c_SW-1:0]   w_s;
      logic                     w_hi, w_lo;

      logic signed [c_DW1-1:0]  r_d;
      logic signed [DW-1:0]     r_gam1, r_gam2, r_gam3;
      logic signed [DW-1:0]     r_bet1, r_bet2, r_bet3, r_bet4;
      logic signed [c_P1W-1:0]  r_p1;
      logic signed [c_NW-1:0]   r_n;
      logic signed [c_P2W-1:0]  r_p2;
      logic signed [DW-1:0]     r_y;
      logic                     r_sat;

      assign w_raw = $signed(i_raw_flat[DW*g +: DW]);
      assign w_gam = $signed(i_gamma_flat[DW*g +: DW]);
      assign w_bet = $signed(i_beta_flat[DW*g +: DW]);

      assign w_p1  = c_P1W'(r_d) * c_P1W'(r_inv);
      assign w_p1r = r_p1 + c_RND1;
      assign w_n   = c_NW'(w_p1r >>> FRAC);
      assign w_p2  = c_P2W'(r_n) * c_P2W'(r_gam3);
      assign w_p2r = c_P2RW'(r_p2) + c_RND2;
      assign w_t   = w_p2r >>> FRAC;
      assign w_s   = c_SW'(w_t) + c_SW'(r_bet4);
      assign w_hi  = (w_s > c_MAX);
      assign w_lo  = (w_s < c_MIN);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_d    <= '0;
          r_gam1 <= '0;
          r_gam2 <= '0;
          r_gam3 <= '0;
          r_bet1 <= '0;
          r_bet2 <= '0;
          r_bet3 <= '0;
          r_bet4 <= '0;
          r_p1   <= '0;
          r_n    <= '0;
          r_p2   <= '0;
          r_y    <= '0;
          r_sat  <= 1'b0;
        end else if (w_adv) begin
          r_d    <= c_DW1'(w_raw) - c_DW1'(i_mean);
          r_gam1 <= w_gam;
          r_bet1 <= w_bet;
          r_p1   <= w_p1;
          r_gam2 <= r_gam1;
          r_bet2 <= r_bet1;
          r_n    <= w_n;
          r_gam3 <= r_gam2;
          r_bet3 <= r_bet2;
          r_p2   <= w_p2;
          r_bet4 <= r_bet3;
          r_y    <= w_hi ? c_YMAX : (w_lo ? c_YMIN : w_s[DW-1:0]);
          r_sat  <= w_hi | w_lo;
        end
      end

      assign o_data_flat[DW*g +: DW] = r_y;
      assign o_sat_mask[g]           = r_sat;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ln_normalize_affine_pipe.sv
`default_nettype none
// Bench for ln_normalize_affine_pipe: two default-width instances (ROUND 1/0)
// and two wide 4-lane instances (ROUND 1/0), scoreboarded against a model.
module tb_ln_normalize_affine_pipe;

  typedef struct packed {
    logic [5:0]        addr;
    logic [63:0]       mask;
    logic [63:0][23:0] y;
    logic [31:0]       acc;
    logic              lat;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, clr = 1'b0, rnd_rdy = 1'b0;
  logic va = 1'b0, vb = 1'b0;
  logic [5:0] aa = '0, ab = '0;
  logic signed [15:0] ma = '0;
  logic signed [16:0] ia = '0;
  logic signed [23:0] mb = '0;
  logic signed [24:0] ib = '0;
  logic [1023:0] ra = '0, ga = '0, ba = '0;
  logic [95:0] rb = '0, gb = '0, bb = '0;

  logic ov [4], ordy [4], ostk [4];
  logic [5:0] oa [4];
  logic [1023:0] od [4], p_od [4];
  logic [63:0] om [4], p_om [4];
  logic [5:0] p_oa [4];
  logic prev_stall [4];
  logic [95:0] odb [2];
  logic [3:0] omb [2];

  longint t_raw [64], t_gam [64], t_bet [64];
  exp_t sb [4][$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  assign od[2] = {928'b0, odb[0]};
  assign od[3] = {928'b0, odb[1]};
  assign om[2] = {60'b0, omb[0]};
  assign om[3] = {60'b0, omb[1]};

  ln_normalize_affine_pipe #(.ROUND(1)) u_a1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(va), .o_ready(ordy[0]), .i_addr(aa),
    .i_mean(ma), .i_inv_sqrt(ia), .i_raw_flat(ra), .i_gamma_flat(ga), .i_beta_flat(ba),
    .o_valid(ov[0]), .i_ready(rdy), .o_data_flat(od[0]), .o_addr(oa[0]),
    .o_sat_mask(om[0]), .o_sat_sticky(ostk[0]), .i_sat_clr(clr));

  ln_normalize_affine_pipe #(.ROUND(0)) u_a0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(va), .o_ready(ordy[1]), .i_addr(aa),
    .i_mean(ma), .i_inv_sqrt(ia), .i_raw_flat(ra), .i_gamma_flat(ga), .i_beta_flat(ba),
    .o_valid(ov[1]), .i_ready(rdy), .o_data_flat(od[1]), .o_addr(oa[1]),
    .o_sat_mask(om[1]), .o_sat_sticky(ostk[1]), .i_sat_clr(clr));

  ln_normalize_affine_pipe #(.LANES(4), .DW(24), .INV_W(25), .FRAC(16), .ADDR_W(6), .ROUND(1)) u_b1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vb), .o_ready(ordy[2]), .i_addr(ab),
    .i_mean(mb), .i_inv_sqrt(ib), .i_raw_flat(rb), .i_gamma_flat(gb), .i_beta_flat(bb),
    .o_valid(ov[2]), .i_ready(rdy), .o_data_flat(odb[0]), .o_addr(oa[2]),
    .o_sat_mask(omb[0]), .o_sat_sticky(ostk[2]), .i_sat_clr(clr));

  ln_normalize_affine_pipe #(.LANES(4), .DW(24), .INV_W(25), .FRAC(16), .ADDR_W(6), .ROUND(0)) u_b0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vb), .o_ready(ordy[3]), .i_addr(ab),
    .i_mean(mb), .i_inv_sqrt(ib), .i_raw_flat(rb), .i_gamma_flat(gb), .i_beta_flat(bb),
    .o_valid(ov[3]), .i_ready(rdy), .o_data_flat(odb[1]), .o_addr(oa[3]),
    .o_sat_mask(omb[1]), .o_sat_sticky(ostk[3]), .i_sat_clr(clr));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic longint shr(input longint v, input int fr, input bit rnd);
    return rnd ? ((v + (64'sd1 <<< (fr - 1))) >>> fr) : (v >>> fr);
  endfunction

  function automatic void model(input int dw, input int fr, input bit rnd,
                                input longint raw, input longint mean, input longint inv,
                                input longint gam, input longint bet,
                                output longint y, output bit sat);
    longint n, t, mx, mn;
    n  = shr((raw - mean) * inv, fr, rnd);
    t  = shr(n * gam, fr, rnd) + bet;
    mx = (64'sd1 <<< (dw - 1)) - 1;
    mn = -mx - 1;
    sat = (t > mx) || (t < mn);
    y   = (t > mx) ? mx : ((t < mn) ? mn : t);
  endfunction

  // Drives one beat into config cfg and records the expected result for both rounding modes.
  task automatic send(input int cfg, input logic [5:0] addr, input longint mean,
                      input longint inv, input bit lat);
    exp_t e [2];
    int nl, dw, fr, w;
    longint y;
    bit s;
    nl = (cfg == 0) ? 64 : 4;
    dw = (cfg == 0) ? 16 : 24;
    fr = (cfg == 0) ? 10 : 16;
    for (int r = 0; r < 2; r++) e[r] = '0;
    for (int g = 0; g < nl; g++) begin
      for (int r = 0; r < 2; r++) begin
        model(dw, fr, (r == 0), t_raw[g], mean, inv, t_gam[g], t_bet[g], y, s);
        e[r].y[g]    = y[23:0];
        e[r].mask[g] = s;
      end
      if (cfg == 0) begin
        ra[g*16 +: 16] = t_raw[g][15:0];
        ga[g*16 +: 16] = t_gam[g][15:0];
        ba[g*16 +: 16] = t_bet[g][15:0];
      end else begin
        rb[g*24 +: 24] = t_raw[g][23:0];
        gb[g*24 +: 24] = t_gam[g][23:0];
        bb[g*24 +: 24] = t_bet[g][23:0];
      end
    end
    for (int r = 0; r < 2; r++) begin
      e[r].addr = addr;
      e[r].lat  = lat;
    end
    if (cfg == 0) begin aa = addr; ma = mean[15:0]; ia = inv[16:0]; va = 1'b1; end
    else          begin ab = addr; mb = mean[23:0]; ib = inv[24:0]; vb = 1'b1; end
    w = 0;
    @(negedge clk);
    while (!ordy[2*cfg] && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) check("accept_timeout", 64'd1, 64'd0);
    else begin
      for (int r = 0; r < 2; r++) begin
        e[r].acc = cyc;
        sb[2*cfg + r].push_back(e[r]);
      end
    end
    @(posedge clk);
    #1;
    if (cfg == 0) va = 1'b0; else vb = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && w < 1000) begin
      w++;
      @(negedge clk);
    end
    if (w >= 1000) check("drain_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input longint raw, input longint gam, input longint bet);
    for (int g = 0; g < 64; g++) begin
      t_raw[g] = raw;
      t_gam[g] = gam;
      t_bet[g] = bet;
    end
  endtask

  task automatic check_reset(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      check($sformatf("rst_valid%0d", i), 64'(ov[i]), 64'd0);
      check($sformatf("rst_data%0d", i), 64'(od[i] !== '0), 64'd0);
      check($sformatf("rst_addr%0d", i), 64'(oa[i]), 64'd0);
      check($sformatf("rst_mask%0d", i), om[i], 64'd0);
      check($sformatf("rst_sticky%0d", i), 64'(ostk[i]), 64'd0);
      check($sformatf("rst_ready%0d", i), 64'(ordy[i]), 64'd1);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    rdy = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor: handshake rule, stall stability and scoreboard pops.
  always @(negedge clk) begin : mon
    exp_t e;
    int nl, dw;
    logic [63:0] lm, mm;
    logic [1023:0] sh;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) prev_stall[i] = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("o_ready%0d", i), 64'(ordy[i]), 64'(!ov[i] || rdy));
        if (prev_stall[i]) begin
          check($sformatf("stall_valid%0d", i), 64'(ov[i]), 64'd1);
          check($sformatf("stall_data%0d", i), 64'(od[i] !== p_od[i]), 64'd0);
          check($sformatf("stall_addr%0d", i), 64'(oa[i]), 64'(p_oa[i]));
          check($sformatf("stall_mask%0d", i), om[i], p_om[i]);
        end
        if (ov[i] && rdy) begin
          if (sb[i].size() == 0) check($sformatf("unexpected_beat%0d", i), 64'd1, 64'd0);
          else begin
            e  = sb[i].pop_front();
            nl = (i < 2) ? 64 : 4;
            dw = (i < 2) ? 16 : 24;
            lm = (64'd1 << dw) - 64'd1;
            mm = (i < 2) ? '1 : 64'hF;
            check($sformatf("addr%0d", i), 64'(oa[i]), 64'(e.addr));
            check($sformatf("mask%0d", i), om[i] & mm, e.mask);
            for (int g = 0; g < nl; g++) begin
              sh = od[i] >> (g * dw);
              check($sformatf("lane%0d_%0d", i, g), sh[63:0] & lm, 64'(e.y[g]) & lm);
            end
            if (e.lat) check($sformatf("latency%0d", i), 64'(cyc - int'(e.acc)), 64'd5);
          end
        end
        prev_stall[i] = ov[i] && !rdy;
        p_od[i] = od[i];
        p_oa[i] = oa[i];
        p_om[i] = om[i];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset(0, 3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unity path
    fill(2048, 1024, 0);
    send(0, 6'd5, 1024, 1024, 1'b1);
    drain();

    // Positive and negative saturation with sticky clear
    fill(32767, 1024, 0);
    send(0, 6'd6, -32768, 4096, 1'b1);
    drain();
    check("sticky_set0", 64'(ostk[0]), 64'd1);
    check("sticky_set1", 64'(ostk[1]), 64'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("sticky_clr0", 64'(ostk[0]), 64'd0);
    check("sticky_clr1", 64'(ostk[1]), 64'd0);
    fill(32767, -1024, 0);
    send(0, 6'd7, -32768, 4096, 1'b1);
    drain();
    check("sticky_reset0", 64'(ostk[0]), 64'd1);

    // Rounding
    fill(1, 1024, 0);
    send(0, 6'd8, 0, 512, 1'b1);
    fill(-1, 1024, 0);
    send(0, 6'd9, 0, 512, 1'b1);
    drain();

    // Backpressure stream
    rnd_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      for (int g = 0; g < 64; g++) begin
        t_raw[g] = k * 37 + g * 101 - 3000;
        t_gam[g] = 212 + g * 13;
        t_bet[g] = g * 5 - 100;
      end
      send(0, 6'(k), 100, 900, 1'b0);
    end
    rnd_rdy = 1'b0;
    drain();

    // Reset with three beats in flight
    fill(500, 700, 3);
    for (int k = 0; k < 3; k++) send(0, 6'(40 + k), 10, 1500, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset(0, 1);
    for (int i = 0; i < 4; i++) sb[i].delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    fill(-700, 900, -20);
    send(0, 6'd50, 300, 1100, 1'b1);
    drain();

    // Wide-configuration sweep with random operands and backpressure
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      longint mean, inv;
      for (int g = 0; g < 4; g++) begin
        t_raw[g] = longint'($signed(24'($urandom)));
        t_gam[g] = longint'($signed(24'($urandom)));
        t_bet[g] = longint'($signed(24'($urandom)));
        if (k % 2 == 1) begin
          t_raw[g] = t_raw[g] >>> 4;
          t_gam[g] = t_gam[g] >>> 6;
          t_bet[g] = t_bet[g] >>> 2;
        end
      end
      mean = longint'($signed(24'($urandom)));
      inv  = longint'($signed(25'($urandom)));
      if (k % 2 == 1) begin
        mean = mean >>> 4;
        inv  = inv >>> 10;
      end
      send(1, 6'(k), mean, inv, 1'b0);
    end
    rnd_rdy = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
